t04_mem_request_fsm: RTL and testbench
======================================

Name: t04_mem_request_fsm

Overview:
Successor to the team's single-port instruction/data request unit. It sequences instruction fetch and load/store accesses over one shared memory port using an explicit req/ack FSM. It adds byte/halfword/word sizing with byte enables, load sign/zero extension, misalignment detection and a bus timeout. It sits between the core datapath (PC, ALU address, store data, decoder controls) and the memory/wishbone-side handshake, and drives the core-wide freeze.

Parameters:
ADDR_W, 32, width of PC, data address and mem_addr
TIMEOUT, 255, cycles to wait for mem_ack before aborting; 0 disables the timeout
NOP_INSTR, 32'h00000013, instruction substituted on a fetch abort

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
pc  in  ADDR_W  fetch address
mem_address  in  ADDR_W  load/store byte address
stored_data  in  32  store data, right-aligned
MemRead  in  1  decoded load, valid in EXEC
MemWrite  in  1  decoded store, valid in EXEC
mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
load_unsigned  in  1  1 = zero-extend loads
mem_rdata  in  32  memory read data
mem_ack  in  1  memory handshake complete
mem_req  out  1  request, held until ack or abort
mem_we  out  1  write request
mem_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0)
mem_wdata  out  32  store data replicated into lanes
mem_be  out  4  byte enables
instruction_out  out  32  registered current instruction
load_data  out  32  registered extended load result
freeze  out  1  stall PC and register writeback
misaligned  out  1  one-cycle pulse on a misaligned access
bus_err  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- Reset: state IDLE; mem_req=0, mem_we=0, mem_be=0, instruction_out=0, load_data=0, freeze=1, misaligned=0, bus_err=0, timeout counter=0. rst asserted in any state returns to IDLE at that edge, and mem_req is low the next cycle.
- States and transitions:
  - IDLE: next state is always FETCH.
  - FETCH: mem_req=1, mem_we=0, mem_be=4'hF, mem_addr=pc.
  - On an edge with mem_ack=1: instruction_out<=mem_rdata, go to EXEC.
  - EXEC: mem_req=0. If MemRead or MemWrite, check alignment.
    - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
    - If misaligned: pulse misaligned, freeze=0 this cycle, go to FETCH.
    - If aligned: freeze=1, go to DATA.
    - If neither MemRead nor MemWrite: freeze=0 this cycle, go to FETCH.
  - DATA: mem_req=1, mem_we=MemWrite, mem_addr=mem_address.
  - On ack: if read, load_data<=extended lane of mem_rdata; go to WB.
  - WB: freeze=0 for one cycle, go to FETCH.
- freeze is 1 in every state/cycle except the single commit cycle (EXEC with no access, misaligned EXEC, or WB).
- Throughput with zero-wait ack: 2 cycles per non-memory instruction, 4 per load/store.
- Byte lanes, with a = mem_address[1:0]:
  - byte: be=1<<a, wdata={4{sd[7:0]}}.
  - half: be=4'b0011<<a, wdata={2{sd[15:0]}}.
  - word: be=4'hF, wdata=sd.
  - Load extracts the lane at a and sign-extends unless load_unsigned=1.
- mem_req, mem_addr, mem_we, mem_be, mem_wdata are stable while a request is held. mem_ack is ignored when mem_req=0.
- Timeout (TIMEOUT>0):
  - The counter clears on entry to FETCH/DATA and increments each cycle with no ack.
  - When it reaches TIMEOUT with no ack: mem_req drops next cycle and bus_err<=1.
  - FETCH abort: instruction_out<=NOP_INSTR, go to EXEC.
  - DATA abort: load_data<=0, go to WB.
  - An ack arriving in the same cycle as the timeout wins (normal completion).

Test Plan:
- Reset then ack every cycle, pc=0x100, rdata=0x00A00093 → mem_addr=0x100, be=F; instruction_out=0x00A00093 after 1 cycle; freeze low exactly 1 cycle in EXEC.
- Store byte, mem_address=0x203, sd=0x55 → mem_we=1, mem_addr=0x200, be=4'b1000, wdata=0x55555555; freeze low only in WB.
- Load half signed at 0x102, rdata=0x8001_0000 → load_data=0xFFFF8001; same access with load_unsigned=1 → 0x00008001.
- Load word at 0x101 → misaligned pulses 1 cycle, no DATA request issued, next state FETCH.
- TIMEOUT=4, ack withheld in FETCH → mem_req high 4 cycles then low, bus_err=1, instruction_out=0x00000013.
- rst asserted mid-DATA with ack low → next cycle mem_req=0, freeze=1, state IDLE; fetch resumes with FETCH one cycle later.

Source files
------------

// File: rtl/t04_mem_request_fsm.sv
// Shared-port request sequencer: instruction fetch, then optional load/store, over one req/ack bus.
// Adds byte lanes, load extension, misalignment detection, a bus timeout and the core-wide freeze.
module t04_mem_request_fsm #(
    parameter int          ADDR_W    = 32,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [31:0]       stored_data,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        mem_size,
    input  logic              load_unsigned,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic [31:0]       instruction_out,
    output logic [31:0]       load_data,
    output logic              freeze,
    output logic              misaligned,
    output logic              bus_err,
    output logic [2:0]        fsm_state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        DATA  = 3'd3,
        WB    = 3'd4
    } state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] load_q, load_d;
    logic        bus_err_q, bus_err_d;

    logic [1:0]  lane;
    logic        is_byte, is_half, is_word;
    logic        misalign_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic        timeout_hit;
    logic        pc_lo_unused;

    // Fetches are always word-aligned; the low PC bits carry no meaning here.
    assign pc_lo_unused = ^pc[1:0];

    assign lane    = mem_address[1:0];
    assign is_byte = (mem_size == 2'b00);
    assign is_half = (mem_size == 2'b01);
    assign is_word = !is_byte && !is_half;

    assign misalign_c = (is_half && lane[0]) || (is_word && (lane != 2'b00));

    always_comb begin
        be_c    = 4'hF;
        wdata_c = stored_data;
        if (is_byte) begin
            be_c    = 4'b0001 << lane;
            wdata_c = {4{stored_data[7:0]}};
        end else if (is_half) begin
            be_c    = 4'b0011 << lane;
            wdata_c = {2{stored_data[15:0]}};
        end
    end

    // Bring the addressed lane down to bit 0, then extend to 32 bits.
    assign shifted = mem_rdata >> {lane, 3'b000};

    always_comb begin
        load_ext = mem_rdata;
        if (is_byte) begin
            load_ext = {{24{!load_unsigned && shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            load_ext = {{16{!load_unsigned && shifted[15]}}, shifted[15:0]};
        end
    end

    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        load_d     = load_q;
        bus_err_d  = bus_err_q;
        cnt_d      = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = 4'h0;
        freeze     = 1'b1;
        misaligned = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_be   = 4'hF;
                mem_addr = {pc[ADDR_W-1:2], 2'b00};
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    state_d = EXEC;
                end else if (timeout_hit) begin
                    instr_d   = NOP_INSTR;
                    bus_err_d = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (MemRead || MemWrite) begin
                    if (misalign_c) begin
                        misaligned = 1'b1;
                        freeze     = 1'b0;
                        state_d    = FETCH;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    freeze  = 1'b0;
                    state_d = FETCH;
                end
            end
            DATA: begin
                mem_req   = 1'b1;
                mem_we    = MemWrite;
                mem_addr  = {mem_address[ADDR_W-1:2], 2'b00};
                mem_be    = be_c;
                mem_wdata = wdata_c;
                if (mem_ack) begin
                    if (MemRead) begin
                        load_d = load_ext;
                    end
                    state_d = WB;
                end else if (timeout_hit) begin
                    load_d    = '0;
                    bus_err_d = 1'b1;
                    state_d   = WB;
                end
            end
            WB: begin
                freeze  = 1'b0;
                state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counter restarts on every state change and only runs while a request is held.
        if (state_d == state_q && mem_req) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            instr_q   <= '0;
            load_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            load_q    <= load_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign instruction_out = instr_q;
    assign load_data       = load_q;
    assign bus_err         = bus_err_q;
    assign fsm_state_o     = state_q;

endmodule

// File: tb/tb_t04_mem_request_fsm.sv
// Directed bench for t04_mem_request_fsm: fetch, store/load lanes, misalignment, timeouts, reset.
module tb_t04_mem_request_fsm;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] mem_address;
    logic [31:0] stored_data;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  mem_size;
    logic        load_unsigned;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] instruction_out;
    logic [31:0] load_data;
    logic        freeze;
    logic        misaligned;
    logic        bus_err;
    logic [2:0]  fsm_state_o;

    int checks;
    int failures;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_FETCH = 32'd1;
    localparam logic [31:0] S_EXEC  = 32'd2;
    localparam logic [31:0] S_DATA  = 32'd3;
    localparam logic [31:0] S_WB    = 32'd4;

    t04_mem_request_fsm #(
        .ADDR_W   (32),
        .TIMEOUT  (4),
        .NOP_INSTR(32'h00000013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .mem_address    (mem_address),
        .stored_data    (stored_data),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .mem_size       (mem_size),
        .load_unsigned  (load_unsigned),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .instruction_out(instruction_out),
        .load_data      (load_data),
        .freeze         (freeze),
        .misaligned     (misaligned),
        .bus_err        (bus_err),
        .fsm_state_o    (fsm_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        pc            = 32'h100;
        mem_address   = '0;
        stored_data   = '0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        mem_size      = 2'b00;
        load_unsigned = 1'b0;
        mem_rdata     = '0;
        mem_ack       = 1'b0;

        // Reset state
        tick(); tick(); settle();
        chk("rst_state", 32'(fsm_state_o), S_IDLE);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_instr", instruction_out, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd1);
        chk("rst_misal", 32'(misaligned), 32'd0);
        chk("rst_buserr", 32'(bus_err), 32'd0);

        // Plain fetch with zero-wait ack
        rst = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h00A00093; settle();
        chk("f1_state", 32'(fsm_state_o), S_FETCH);
        chk("f1_req", 32'(mem_req), 32'd1);
        chk("f1_addr", mem_addr, 32'h100);
        chk("f1_be", 32'(mem_be), 32'hF);
        chk("f1_we", 32'(mem_we), 32'd0);
        chk("f1_freeze", 32'(freeze), 32'd1);
        tick(); settle();
        chk("f1_instr", instruction_out, 32'h00A00093);
        chk("f1_exec_state", 32'(fsm_state_o), S_EXEC);
        chk("f1_exec_freeze", 32'(freeze), 32'd0);
        chk("f1_exec_req", 32'(mem_req), 32'd0);

        // Store byte at 0x203
        tick();
        mem_rdata = 32'h005501A3; settle();
        chk("sb_fetch_state", 32'(fsm_state_o), S_FETCH);
        chk("sb_fetch_freeze", 32'(freeze), 32'd1);
        tick();
        MemWrite = 1'b1; mem_size = 2'b00; mem_address = 32'h203; stored_data = 32'h55; settle();
        chk("sb_exec_freeze", 32'(freeze), 32'd1);
        chk("sb_exec_misal", 32'(misaligned), 32'd0);
        tick(); settle();
        chk("sb_data_state", 32'(fsm_state_o), S_DATA);
        chk("sb_req", 32'(mem_req), 32'd1);
        chk("sb_we", 32'(mem_we), 32'd1);
        chk("sb_addr", mem_addr, 32'h200);
        chk("sb_be", 32'(mem_be), 32'h8);
        chk("sb_wdata", mem_wdata, 32'h55555555);
        chk("sb_data_freeze", 32'(freeze), 32'd1);
        tick(); settle();
        chk("sb_wb_state", 32'(fsm_state_o), S_WB);
        chk("sb_wb_freeze", 32'(freeze), 32'd0);
        chk("sb_wb_req", 32'(mem_req), 32'd0);

        // Load half signed at 0x102
        MemWrite = 1'b0; mem_rdata = 32'h00411083;
        tick(); tick();
        MemRead = 1'b1; mem_size = 2'b01; mem_address = 32'h102; load_unsigned = 1'b0; settle();
        chk("lh_exec_freeze", 32'(freeze), 32'd1);
        tick();
        mem_rdata = 32'h80010000; settle();
        chk("lh_be", 32'(mem_be), 32'hC);
        chk("lh_addr", mem_addr, 32'h100);
        chk("lh_we", 32'(mem_we), 32'd0);
        tick(); settle();
        chk("lh_signed", load_data, 32'hFFFF8001);

        // Same access, zero-extended
        mem_rdata = 32'h00415083;
        tick(); tick();
        load_unsigned = 1'b1;
        tick();
        mem_rdata = 32'h80010000;
        tick(); settle();
        chk("lhu_unsigned", load_data, 32'h00008001);

        // Load byte signed at 0x101
        mem_rdata = 32'h00408083;
        tick(); tick();
        mem_size = 2'b00; mem_address = 32'h101; load_unsigned = 1'b0;
        tick();
        mem_rdata = 32'h1234F078; settle();
        chk("lb_be", 32'(mem_be), 32'h2);
        tick(); settle();
        chk("lb_signed", load_data, 32'hFFFFFFF0);

        // Misaligned load word at 0x101
        mem_rdata = 32'h0040A083;
        tick(); tick();
        mem_size = 2'b10; mem_address = 32'h101; settle();
        chk("mis_pulse", 32'(misaligned), 32'd1);
        chk("mis_freeze", 32'(freeze), 32'd0);
        chk("mis_state", 32'(fsm_state_o), S_EXEC);
        chk("mis_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;

        // Next state is FETCH; ack withheld so this fetch times out
        tick();
        MemRead = 1'b0; mem_size = 2'b00; settle();
        chk("mis_next_state", 32'(fsm_state_o), S_FETCH);
        chk("mis_pulse_end", 32'(misaligned), 32'd0);
        chk("to_f0_req", 32'(mem_req), 32'd1);
        chk("to_f0_addr", mem_addr, 32'h100);
        tick(); settle();
        chk("to_f1_req", 32'(mem_req), 32'd1);
        tick(); settle();
        chk("to_f2_req", 32'(mem_req), 32'd1);
        tick(); settle();
        chk("to_f3_req", 32'(mem_req), 32'd1);
        chk("to_f3_buserr", 32'(bus_err), 32'd0);
        tick(); settle();
        chk("to_abort_req", 32'(mem_req), 32'd0);
        chk("to_abort_state", 32'(fsm_state_o), S_EXEC);
        chk("to_buserr", 32'(bus_err), 32'd1);
        chk("to_nop", instruction_out, 32'h00000013);

        // Data-phase timeout clears load_data
        mem_ack = 1'b1; mem_rdata = 32'h00412083;
        tick(); tick();
        MemRead = 1'b1; mem_size = 2'b10; mem_address = 32'h104; mem_ack = 1'b0; settle();
        chk("dto_exec_freeze", 32'(freeze), 32'd1);
        tick(); settle();
        chk("dto_d0_req", 32'(mem_req), 32'd1);
        chk("dto_d0_addr", mem_addr, 32'h104);
        tick(); tick(); tick(); settle();
        chk("dto_d3_state", 32'(fsm_state_o), S_DATA);
        tick(); settle();
        chk("dto_wb_state", 32'(fsm_state_o), S_WB);
        chk("dto_load_zero", load_data, 32'd0);
        chk("dto_wb_freeze", 32'(freeze), 32'd0);

        // Ack on the timeout cycle wins
        MemRead = 1'b0; mem_rdata = 32'h00B00113;
        tick(); tick(); tick(); tick();
        mem_ack = 1'b1; settle();
        chk("aw_f3_state", 32'(fsm_state_o), S_FETCH);
        tick(); settle();
        chk("aw_state", 32'(fsm_state_o), S_EXEC);
        chk("aw_instr", instruction_out, 32'h00B00113);

        // Reset in the middle of a held data request
        MemRead = 1'b1; mem_size = 2'b10; mem_address = 32'h108; mem_ack = 1'b0;
        tick(); settle();
        chk("rd_data_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick(); settle();
        chk("rd_state", 32'(fsm_state_o), S_IDLE);
        chk("rd_req", 32'(mem_req), 32'd0);
        chk("rd_freeze", 32'(freeze), 32'd1);
        chk("rd_buserr", 32'(bus_err), 32'd0);
        rst = 1'b0;
        tick(); settle();
        chk("rd_resume_state", 32'(fsm_state_o), S_FETCH);
        chk("rd_resume_req", 32'(mem_req), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
